branch_cmp: RTL
===============

# branch_cmp

Parametrised, buffered branch-condition unit for the pipelined CPU: accepts an operand pair, a compare mode and a tag (e.g. the branch PC) over a valid/ready handshake. It evaluates one of eight signed/unsigned conditions and returns the taken bit and tag through a 2-entry result queue. It also keeps saturating taken/total statistics counters. It sits between operand forwarding in decode and the next-PC logic, and replaces the single-width equality comparator.

## Interface
- WIDTH, 32, operand width in bits (≥2)
- TAG_W, 32, width of the tag carried with each result
- CNT_W, 16, width of the statistics counters
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- in_mode  in  3  compare mode (encoding in Operation)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored by zero-compare modes)
- in_tag  in  TAG_W  tag returned with result
- out_valid  out  1  result available at queue head
- out_ready  in  1  consumer takes head this cycle
- out_taken  out  1  condition result of head entry
- out_tag  out  TAG_W  tag of head entry
- flush  in  1  synchronous discard of queued and incoming requests
- cnt_clr  in  1  synchronous clear of statistics counters
- total_cnt  out  CNT_W  accepted requests, saturating
- taken_cnt  out  CNT_W  accepted requests evaluated taken, saturating

## Operation
- Modes: 0 EQ a==b; 1 NE a!=b; 2 LTZ a<0; 3 GEZ a≥0; 4 LEZ a≤0; 5 GTZ a>0; 6 LT signed a<b; 7 LTU unsigned a<b.
- Signedness comes from the MSB of in_a/in_b at WIDTH. Zero modes test in_a only.
- Accept = in_valid && in_ready && !flush. On accept, the condition is evaluated combinationally and {taken, tag} is written to the queue tail.
- Queue: 2 entries, FIFO order. in_ready = (occupancy < 2). It depends on registered occupancy only, with no combinational path from out_ready.
- Pop = out_valid && out_ready && !flush. out_valid = occupancy > 0. out_taken/out_tag show the head entry and hold stable while out_valid && !out_ready.
- Push and pop in the same cycle: occupancy unchanged, order preserved. Push does not occur at occupancy 2.
- flush: occupancy → 0 next cycle; the same-cycle input is not accepted and not counted; the same-cycle pop is not counted as a transfer.
- Counters: on accept, total_cnt += 1, and taken_cnt += 1 if taken. Each saturates at 2^CNT_W−1 and does not wrap.
- cnt_clr zeroes both counters. cnt_clr together with accept gives 0, with clear taking priority.
- Flushed entries remain counted.

## Timing
- Reset (async assert, sync-safe deassert): occupancy 0, out_valid 0, in_ready 1, out_taken 0, out_tag 0, total_cnt 0, taken_cnt 0. Queue storage is reset to 0.
- Latency: a request accepted at edge N is visible on out_valid/out_taken/out_tag after edge N, in cycle N+1.
- Throughput: 1 request/cycle while the consumer pops every cycle.
- Counters update at the same edge as the accept; the new value is visible in the next cycle.
- Reset asserted mid-operation: all queued entries are lost immediately, with no partial output.

## Structure
- Shared package cmp_pkg holds the 3-bit mode constants (CMP_EQ … CMP_LTU) and the mode typedef. Decode uses it too.
- One sub-module: cmp_cond, purely combinational (mode, a, b → taken), parametrised by WIDTH and reusable by the ALU.
- Queue and counters are inline in branch_cmp.

## Test plan
- Reset then idle → in_ready=1, out_valid=0, counters 0. Then WIDTH=32: EQ a=b=0x1234 tag=0x3000 → next cycle out_valid=1, taken=1, tag=0x3000, total=1, taken_cnt=1.
- Sign boundaries with WIDTH=32 and a=0x80000000, b=0x00000001: LT→1, LTU→0, LTZ→1, GEZ→0, LEZ→1, GTZ→0. Then a=0: LEZ→1, GTZ→0, GEZ→1.
- Backpressure: out_ready=0, push 3 requests back-to-back. The first two are accepted; in_ready=0 on the third; the head is stable. Release out_ready → outputs appear in order, then the third is accepted.
- Simultaneous push/pop at occupancy 1 → occupancy stays 1 and FIFO order is intact over 10 streamed requests with alternating taken.
- Flush with 2 queued plus a valid input → next cycle out_valid=0, in_ready=1, total_cnt unchanged by the flushed-cycle input.
- CNT_W=4: 20 taken accepts → total_cnt=taken_cnt=15. Then cnt_clr together with an accept → both 0 next cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared compare-mode encoding for the branch unit and decode.
package cmp_pkg;

   typedef enum logic [2:0] {
      CMP_EQ  = 3'd0,
      CMP_NE  = 3'd1,
      CMP_LTZ = 3'd2,
      CMP_GEZ = 3'd3,
      CMP_LEZ = 3'd4,
      CMP_GTZ = 3'd5,
      CMP_LT  = 3'd6,
      CMP_LTU = 3'd7
   } cmp_mode_e;

   localparam int unsigned QDEPTH = 2;

endpackage

// File: rtl/cmp_cond.sv
// Combinational condition evaluator: one of eight signed/unsigned compares.
module cmp_cond
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  cmp_mode_e          mode_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               taken_o
);

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic                    a_neg;
   logic                    a_zero;

   assign a_s    = $signed(a_i);
   assign b_s    = $signed(b_i);
   assign a_neg  = a_i[WIDTH-1];
   assign a_zero = (a_i == '0);

   // Zero-compare modes look at operand A only.
   always_comb begin
      taken_o = 1'b0;
      case (mode_i)
         CMP_EQ:  taken_o = (a_i == b_i);
         CMP_NE:  taken_o = (a_i != b_i);
         CMP_LTZ: taken_o = a_neg;
         CMP_GEZ: taken_o = !a_neg;
         CMP_LEZ: taken_o = a_neg || a_zero;
         CMP_GTZ: taken_o = !a_neg && !a_zero;
         CMP_LT:  taken_o = (a_s < b_s);
         CMP_LTU: taken_o = (a_i < b_i);
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cmp.sv
// Buffered branch-condition unit: evaluates a compare on accept, returns
// {taken, tag} through a 2-entry FIFO, and keeps saturating statistics.
module branch_cmp
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 32,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_mode,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_taken,
   output logic [TAG_W-1:0]  out_tag,
   input  logic              flush,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  total_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic             cond_taken;
   logic             push;
   logic             pop;

   logic [1:0]       occ_q, occ_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             taken_q [QDEPTH];
   logic [TAG_W-1:0] tag_q   [QDEPTH];
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] takn_q,  takn_d;

   cmp_cond #(.WIDTH(WIDTH)) u_cond (
      .mode_i  (cmp_mode_e'(in_mode)),
      .a_i     (in_a),
      .b_i     (in_b),
      .taken_o (cond_taken)
   );

   // Ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = (occ_q != 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign out_taken = taken_q[rd_ptr_q];
   assign out_tag   = tag_q[rd_ptr_q];
   assign total_cnt = total_q;
   assign taken_cnt = takn_q;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      occ_d    = occ_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         occ_d    = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = !wr_ptr_q;
         if (pop)  rd_ptr_d = !rd_ptr_q;
         if (push && !pop)      occ_d = occ_q + 2'd1;
         else if (pop && !push) occ_d = occ_q - 2'd1;
      end
   end

   // Clear wins over a same-cycle accept.
   always_comb begin
      total_d = total_q;
      takn_d  = takn_q;
      if (cnt_clr) begin
         total_d = '0;
         takn_d  = '0;
      end else if (push) begin
         total_d = sat_inc(total_q);
         if (cond_taken) takn_d = sat_inc(takn_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q      <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         taken_q[0] <= 1'b0;
         taken_q[1] <= 1'b0;
         tag_q[0]   <= '0;
         tag_q[1]   <= '0;
         total_q    <= '0;
         takn_q     <= '0;
      end else begin
         occ_q    <= occ_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         total_q  <= total_d;
         takn_q   <= takn_d;
         if (push) begin
            taken_q[wr_ptr_q] <= cond_taken;
            tag_q[wr_ptr_q]   <= in_tag;
         end
      end
   end

endmodule
